// File: rtl/mxint8_block_gather_pkg.sv
// Shared MXINT8 constants and types used by the block gather front end.
package mxint8_block_gather_pkg;

    localparam int MX_BLOCK_SIZE        = 32;
    localparam int MX_SCALE_WIDTH       = 8;
    localparam int MXINT8_ELEMENT_WIDTH = 8;
    localparam int MX_LANES             = 4;
    localparam int BEATS                = MX_BLOCK_SIZE / MX_LANES;

    typedef struct {
        logic [MX_SCALE_WIDTH-1:0]       scale;
        logic [MXINT8_ELEMENT_WIDTH-1:0] elements [MX_BLOCK_SIZE];
    } mxint8_block_t;

    typedef enum logic {
        BUF_A = 1'b0,
        BUF_B = 1'b1
    } buf_sel_t;

    function automatic buf_sel_t other_buf(input buf_sel_t s);
        return (s == BUF_A) ? BUF_B : BUF_A;
    endfunction

    // Counter width that stays legal when a block is a single beat.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mxint8_block_buf.sv
// One block buffer: lane-granular element writes, scale capture on the
// first beat and zero-fill of all slots beyond a short final beat.
module mxint8_block_buf
    import mxint8_block_gather_pkg::*;
#(
    parameter int LANES       = MX_LANES,
    parameter int BLOCK_SIZE  = MX_BLOCK_SIZE,
    parameter int SCALE_WIDTH = MX_SCALE_WIDTH,
    parameter int ELEM_WIDTH  = MXINT8_ELEMENT_WIDTH,
    parameter int IDX_W       = idx_width(BLOCK_SIZE / LANES)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_en,
    input  logic                        scale_en,
    input  logic                        zero_fill,
    input  logic [IDX_W-1:0]            beat,
    input  logic [SCALE_WIDTH-1:0]      scale_in,
    input  logic [LANES*ELEM_WIDTH-1:0] lanes_in,
    output logic [SCALE_WIDTH-1:0]      scale,
    output logic [ELEM_WIDTH-1:0]       elements [BLOCK_SIZE]
);

    always_ff @(posedge clk) begin
        if (rst) begin
            scale <= '0;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                elements[i] <= '0;
            end
        end else if (wr_en) begin
            if (scale_en) begin
                scale <= scale_in;
            end
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                if (IDX_W'(i / LANES) == beat) begin
                    elements[i] <= lanes_in[(i % LANES)*ELEM_WIDTH +: ELEM_WIDTH];
                end else if (zero_fill && (IDX_W'(i / LANES) > beat)) begin
                    elements[i] <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/mxint8_block_gather.sv
// Assembles a beat stream of LANES elements into full MXINT8 blocks,
// ping-ponging between two buffers so input continues while a block waits.
module mxint8_block_gather
    import mxint8_block_gather_pkg::*;
#(
    parameter int LANES       = MX_LANES,
    parameter int BLOCK_SIZE  = MX_BLOCK_SIZE,
    parameter int SCALE_WIDTH = MX_SCALE_WIDTH,
    parameter int ELEM_WIDTH  = MXINT8_ELEMENT_WIDTH
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_in_valid,
    output logic                        o_in_ready,
    input  logic [SCALE_WIDTH-1:0]      i_in_scale,
    input  logic [LANES*ELEM_WIDTH-1:0] i_in_elements,
    input  logic                        i_in_last,
    output logic                        o_out_valid,
    input  logic                        i_out_ready,
    output logic [SCALE_WIDTH-1:0]      o_scale,
    output logic [ELEM_WIDTH-1:0]       o_mxint8_elements [BLOCK_SIZE],
    output logic                        o_frame_err
);

    localparam int BLOCK_BEATS = BLOCK_SIZE / LANES;
    localparam int IDX_W       = idx_width(BLOCK_BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BEATS - 1);

    logic [IDX_W-1:0]       beat_idx;
    buf_sel_t               wsel;
    buf_sel_t               rsel;
    logic [1:0]             full_cnt;
    logic                   accept;
    logic                   last_slot;
    logic                   complete;
    logic                   pop;
    logic                   early_last;
    logic                   missing_last;
    logic                   first_beat;
    logic                   wr_a;
    logic                   wr_b;
    logic [SCALE_WIDTH-1:0] scale_a;
    logic [SCALE_WIDTH-1:0] scale_b;
    logic [ELEM_WIDTH-1:0]  elems_a [BLOCK_SIZE];
    logic [ELEM_WIDTH-1:0]  elems_b [BLOCK_SIZE];

    // Ready depends only on held state, so it never combinationally follows i_out_ready.
    assign o_in_ready   = (full_cnt < 2'd2);
    assign o_out_valid  = (full_cnt != 2'd0);
    assign accept       = i_in_valid && o_in_ready;
    assign last_slot    = (beat_idx == LAST_IDX);
    assign complete     = accept && (last_slot || i_in_last);
    assign pop          = o_out_valid && i_out_ready;
    assign early_last   = accept && i_in_last && !last_slot;
    assign missing_last = accept && last_slot && !i_in_last;
    assign first_beat   = (beat_idx == '0);
    assign wr_a         = accept && (wsel == BUF_A);
    assign wr_b         = accept && (wsel == BUF_B);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            beat_idx    <= '0;
            wsel        <= BUF_A;
            rsel        <= BUF_A;
            full_cnt    <= 2'd0;
            o_frame_err <= 1'b0;
        end else begin
            o_frame_err <= early_last || missing_last;
            if (complete) begin
                beat_idx <= '0;
                wsel     <= other_buf(wsel);
            end else if (accept) begin
                beat_idx <= beat_idx + IDX_W'(1);
            end
            if (pop) begin
                rsel <= other_buf(rsel);
            end
            case ({complete, pop})
                2'b10:   full_cnt <= full_cnt + 2'd1;
                2'b01:   full_cnt <= full_cnt - 2'd1;
                default: full_cnt <= full_cnt;
            endcase
        end
    end

    mxint8_block_buf #(
        .LANES(LANES), .BLOCK_SIZE(BLOCK_SIZE),
        .SCALE_WIDTH(SCALE_WIDTH), .ELEM_WIDTH(ELEM_WIDTH), .IDX_W(IDX_W)
    ) u_buf_a (
        .clk(i_clk), .rst(i_rst), .wr_en(wr_a), .scale_en(first_beat),
        .zero_fill(early_last), .beat(beat_idx), .scale_in(i_in_scale),
        .lanes_in(i_in_elements), .scale(scale_a), .elements(elems_a)
    );

    mxint8_block_buf #(
        .LANES(LANES), .BLOCK_SIZE(BLOCK_SIZE),
        .SCALE_WIDTH(SCALE_WIDTH), .ELEM_WIDTH(ELEM_WIDTH), .IDX_W(IDX_W)
    ) u_buf_b (
        .clk(i_clk), .rst(i_rst), .wr_en(wr_b), .scale_en(first_beat),
        .zero_fill(early_last), .beat(beat_idx), .scale_in(i_in_scale),
        .lanes_in(i_in_elements), .scale(scale_b), .elements(elems_b)
    );

    always_comb begin
        o_scale = (rsel == BUF_B) ? scale_b : scale_a;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            o_mxint8_elements[i] = (rsel == BUF_B) ? elems_b[i] : elems_a[i];
        end
    end

endmodule
